pattern_detector_param: RTL and testbench

//  Parametrised serial bit-pattern detector: next generation of the fixed 4-bit Moore detectors.

---
 rtl/pattern_det_pkg.sv | 21 ++
 rtl/sat_counter.sv | 39 +++
 rtl/pattern_detector_param.sv | 95 +++++++++
 tb/tb_pattern_detector_param.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pattern_det_pkg.sv
// Shared constants and helpers for the serial pattern detectors.
package pattern_det_pkg;

    localparam int unsigned MAX_PAT_W = 32;

    // Common 4-bit target sequences, MSB = first bit received.
    localparam logic [3:0] PAT_1010 = 4'b1010;
    localparam logic [3:0] PAT_1011 = 4'b1011;
    localparam logic [3:0] PAT_0110 = 4'b0110;
    localparam logic [3:0] PAT_1001 = 4'b1001;

    // Masked compare: bits whose mask is 0 are don't-care.
    function automatic logic masked_eq(
        input logic [MAX_PAT_W-1:0] cand,
        input logic [MAX_PAT_W-1:0] pattern,
        input logic [MAX_PAT_W-1:0] mask
    );
        return ((cand ^ pattern) & mask) == '0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
//  clk, reset_n : clock, async active-low reset
//  inc          : add one unless already all-ones
//  clr          : synchronous clear to zero
//  cnt          : registered count
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clear, else increment short of all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pattern_detector_param.sv
// Parametrised serial bit-pattern detector with don't-care mask, overlap
// mode, input qualification and a saturating match counter.
//  clk, reset_n : clock, async active-low reset
//  clear        : synchronous clear of history, fill, pending pulse and count
//  overlap      : 1 = matches may share bits, 0 = restart after each match
//  in_valid     : qualifies in on the current edge
//  in           : serial data bit
//  q            : registered one-cycle match pulse
//  match_cnt    : saturating number of matches
module pattern_detector_param
    import pattern_det_pkg::*;
#(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PAT_1010),
    parameter logic [PAT_W-1:0] MASK    = {PAT_W{1'b1}},
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             overlap,
    input  logic             in_valid,
    input  logic             in,
    output logic             q,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    if ((PAT_W < 2) || (PAT_W > MAX_PAT_W)) begin : g_bad_pat_w
        $error("pattern_detector_param: PAT_W must be in 2..32");
    end

    logic [PAT_W-1:0]  hist_d, hist_q;
    logic [FILL_W-1:0] fill_d, fill_q;
    logic              match_stage_d, match_stage_q;
    logic              q_d, q_q;

    logic [PAT_W-1:0]  cand;
    logic [FILL_W-1:0] fill_inc;
    logic              hit;

    // History, fill and match staging; clear beats a simultaneous valid bit.
    always_comb begin
        hist_d        = hist_q;
        fill_d        = fill_q;
        match_stage_d = 1'b0;
        q_d           = match_stage_q;

        cand     = {hist_q[PAT_W-2:0], in};
        fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        hit      = (fill_inc == FILL_FULL) &&
                   masked_eq(MAX_PAT_W'(cand), MAX_PAT_W'(PATTERN), MAX_PAT_W'(MASK));

        if (clear) begin
            hist_d = '0;
            fill_d = '0;
            q_d    = 1'b0;
        end else if (in_valid) begin
            hist_d        = cand;
            match_stage_d = hit;
            // Non-overlap restarts the fill so the next match shares no bits.
            fill_d        = (hit && !overlap) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q        <= '0;
            fill_q        <= '0;
            match_stage_q <= 1'b0;
            q_q           <= 1'b0;
        end else begin
            hist_q        <= hist_d;
            fill_q        <= fill_d;
            match_stage_q <= match_stage_d;
            q_q           <= q_d;
        end
    end

    // Counter steps on the same edge that raises q.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (match_stage_q),
        .clr     (clear),
        .cnt     (match_cnt)
    );

    assign q = q_q;

endmodule

// File: tb/tb_pattern_detector_param.sv
module tb_pattern_detector_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear;
    logic       overlap;
    logic       in_valid;
    logic       in;

    logic       q_a, q_b, q_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Default 1010 detector.
    pattern_detector_param u_dut_a (
        .clk (clk), .reset_n (reset_n), .clear (clear), .overlap (overlap),
        .in_valid (in_valid), .in (in), .q (q_a), .match_cnt (cnt_a)
    );

    // 1010 with bit 1 don't-care.
    pattern_detector_param #(.MASK (4'b1101)) u_dut_b (
        .clk (clk), .reset_n (reset_n), .clear (clear), .overlap (overlap),
        .in_valid (in_valid), .in (in), .q (q_b), .match_cnt (cnt_b)
    );

    // 2-bit counter for saturation.
    pattern_detector_param #(.CNT_W (2)) u_dut_c (
        .clk (clk), .reset_n (reset_n), .clear (clear), .overlap (overlap),
        .in_valid (in_valid), .in (in), .q (q_c), .match_cnt (cnt_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        in_valid = 1'b0;
        tick();
        clear    = 1'b0;
    endtask

    // Drive n cycles (MSB of the vectors = first cycle) and check q of the
    // selected instance after each edge.
    task automatic run_seq(input string tag, input int sel, input int n,
                           input logic [31:0] bits, input logic [31:0] valid,
                           input logic [31:0] exp_q);
        logic got;
        for (int i = 0; i < n; i++) begin
            in       = bits[n-1-i];
            in_valid = valid[n-1-i];
            tick();
            got = (sel == 0) ? q_a : (sel == 1) ? q_b : q_c;
            check_eq($sformatf("%s_q%0d", tag, i), 32'(got), 32'(exp_q[n-1-i]));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        clear    = 1'b0;
        overlap  = 1'b0;
        in_valid = 1'b0;
        in       = 1'b0;
        #12;
        check_eq("rst_q", 32'(q_a), 32'd0);
        check_eq("rst_cnt", 32'(cnt_a), 32'd0);
        #1 reset_n = 1'b1;
        tick();

        // 1: non-overlap, hits at bits 4 and 8.
        overlap = 1'b0;
        do_clear();
        run_seq("t1", 0, 10, 32'b1010101000, 32'b1111111100, 32'b0000100010);
        check_eq("t1_cnt", 32'(cnt_a), 32'd2);

        // 2: overlap, hits at bits 4, 6 and 8.
        overlap = 1'b1;
        do_clear();
        run_seq("t2", 0, 10, 32'b1010101000, 32'b1111111100, 32'b0000101010);
        check_eq("t2_cnt", 32'(cnt_a), 32'd3);

        // 3: gaps of three idle cycles; one pulse only.
        do_clear();
        run_seq("t3", 0, 17, 32'b11110111111101111, 32'b10001000100010000,
                32'b00000000000001000);
        check_eq("t3_cnt", 32'(cnt_a), 32'd1);

        // 4: masked compare.
        overlap = 1'b0;
        do_clear();
        run_seq("t4a", 1, 5, 32'b10000, 32'b11110, 32'b00001);
        check_eq("t4a_cnt", 32'(cnt_b), 32'd1);
        do_clear();
        run_seq("t4b", 1, 5, 32'b00000, 32'b11110, 32'b00000);
        check_eq("t4b_cnt", 32'(cnt_b), 32'd0);

        // 5: five overlapping matches saturate a 2-bit counter.
        overlap = 1'b1;
        do_clear();
        run_seq("t5", 2, 14, 32'b10101010101000, 32'b11111111111100,
                32'b00001010101010);
        check_eq("t5_cnt", 32'(cnt_c), 32'd3);

        // 6: async reset with a pulse in flight and a 101 prefix held.
        do_clear();
        run_seq("t6a", 0, 5, 32'b10101, 32'b11111, 32'b00001);
        check_eq("t6_pre_cnt", 32'(cnt_a), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t6_async_q", 32'(q_a), 32'd0);
        check_eq("t6_async_cnt", 32'(cnt_a), 32'd0);
        #2 reset_n = 1'b1;
        run_seq("t6b", 0, 6, 32'b010100, 32'b111110, 32'b000001);
        check_eq("t6b_cnt", 32'(cnt_a), 32'd1);

        // Clear together with the completing bit.
        overlap = 1'b0;
        do_clear();
        run_seq("t6c", 0, 3, 32'b101, 32'b111, 32'b000);
        in       = 1'b0;
        in_valid = 1'b1;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check_eq("t6c_q0", 32'(q_a), 32'd0);
        tick();
        check_eq("t6c_q1", 32'(q_a), 32'd0);
        check_eq("t6c_cnt", 32'(cnt_a), 32'd0);

        // Clear kills a staged pulse.
        run_seq("t6d", 0, 4, 32'b1010, 32'b1111, 32'b0000);
        do_clear();
        check_eq("t6d_q0", 32'(q_a), 32'd0);
        tick();
        check_eq("t6d_q1", 32'(q_a), 32'd0);
        check_eq("t6d_cnt", 32'(cnt_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
